// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared constants for the I2C transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int STATE_W  = 3;
    localparam int STATUS_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESP      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_rr_pick
// Description : Combinational round-robin pick, first valid at/after rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_sel;
    int               w_slot;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_sel   = '0;
        w_slot  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot = int'(rr_ptr) + i;
            if (w_slot >= NUM_REQ) begin
                w_slot = w_slot - NUM_REQ;
            end
            w_sel = IDX_W'(w_slot);
            if (!w_found && req_valid[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                idx          = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Round-robin sharing of one I2C master between NUM_REQ clients.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [7*NUM_REQ-1:0]    req_chip_addr,
    input  logic [8*NUM_REQ-1:0]    req_reg_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [STATUS_W-1:0]     rsp_status,
    output logic                    rsp_timeout,
    output logic [6:0]              i2c_chip_addr,
    output logic [7:0]              i2c_reg_addr,
    output logic [DATA_W-1:0]       i2c_data_in,
    output logic                    i2c_write_en,
    output logic                    i2c_read_en,
    input  logic                    i2c_busy,
    input  logic                    i2c_done,
    input  logic [STATUS_W-1:0]     i2c_status,
    input  logic [DATA_W-1:0]       i2c_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_winner;
    logic               r_rw;
    logic [TO_W-1:0]    r_cnt;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [TO_W-1:0]    w_cnt_inc;
    logic               w_cnt_hit;
    logic               w_grant;
    logic               w_complete;
    logic               w_finish;
    logic               w_abort;
    logic               w_en_next;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_pick_grant),
        .idx       (w_pick_idx)
    );

    // Counter value seen in a WAIT cycle is the number of WAIT cycles already spent.
    assign w_cnt_inc = r_cnt + TO_W'(1);
    assign w_cnt_hit = (w_cnt_inc == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i2c_busy)       w_state_next = ST_WAIT_DONE;
                else if (w_cnt_hit) w_state_next = ST_RESP;
            end
            ST_WAIT_DONE: begin
                if (!i2c_busy || i2c_done || w_cnt_hit) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant    = (r_state == ST_IDLE) && (|req_valid);
        w_complete = (r_state == ST_WAIT_DONE) && (!i2c_busy || i2c_done);
        w_finish   = (w_state_next == ST_RESP);
        w_abort    = w_finish && !w_complete;
        w_en_next  = (w_state_next == ST_WAIT_BUSY);
    end

    // Outputs are registered from the next-state view so they align with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_status    <= '0;
            rsp_timeout   <= 1'b0;
            i2c_chip_addr <= '0;
            i2c_reg_addr  <= '0;
            i2c_data_in   <= '0;
            i2c_read_en   <= 1'b0;
            i2c_write_en  <= 1'b0;
            r_rr_ptr      <= '0;
            r_winner      <= '0;
            r_rw          <= 1'b0;
            r_cnt         <= '0;
        end else begin
            req_ready    <= w_grant ? w_pick_grant : '0;
            i2c_read_en  <= w_en_next && !r_rw;
            i2c_write_en <= w_en_next && r_rw;
            rsp_valid    <= '0;
            rsp_timeout  <= 1'b0;

            if (w_grant) begin
                r_winner      <= w_pick_idx;
                r_rw          <= req_rw[w_pick_idx];
                i2c_chip_addr <= req_chip_addr[w_pick_idx*7 +: 7];
                i2c_reg_addr  <= req_reg_addr[w_pick_idx*8 +: 8];
                i2c_data_in   <= req_wdata[w_pick_idx*DATA_W +: DATA_W];
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_finish) begin
                rsp_valid   <= NUM_REQ'(1) << r_winner;
                rsp_timeout <= w_abort;
                rsp_rdata   <= (w_abort || r_rw) ? '0 : i2c_data_out;
                rsp_status  <= i2c_status;
            end

            if (r_state == ST_RESP) begin
                r_rr_ptr <= (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed bench with a small I2C master model for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  req_rw = '0;
    logic [7*NR-1:0] req_chip_addr = '0;
    logic [8*NR-1:0] req_reg_addr = '0;
    logic [DW*NR-1:0] req_wdata = '0;
    logic [NR-1:0]  rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic [3:0]     rsp_status;
    logic           rsp_timeout;
    logic [6:0]     i2c_chip_addr;
    logic [7:0]     i2c_reg_addr;
    logic [DW-1:0]  i2c_data_in;
    logic           i2c_write_en;
    logic           i2c_read_en;
    logic           i2c_busy;
    logic           i2c_done;
    logic [3:0]     i2c_status;
    logic [DW-1:0]  i2c_data_out;

    int total = 0;
    int bad = 0;

    i2c_txn_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TO_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .rsp_timeout(rsp_timeout),
        .i2c_chip_addr(i2c_chip_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_data_in(i2c_data_in),
        .i2c_write_en(i2c_write_en), .i2c_read_en(i2c_read_en),
        .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_status(i2c_status),
        .i2c_data_out(i2c_data_out)
    );

    always #5 clk = ~clk;

    // Master model: 0 = normal, 1 = never goes busy, 2 = stays busy forever.
    int          mode = 0;
    int          m_phase;
    int          m_cnt;
    logic        m_wr;
    logic [7:0]  m_reg;
    logic [15:0] m_wd;
    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_cnt <= 0; m_wr <= 1'b0; m_reg <= '0; m_wd <= '0;
            i2c_busy <= 1'b0; i2c_done <= 1'b0; i2c_status <= '0; i2c_data_out <= '0;
            mem[0] <= 16'hA1A1;
            mem[1] <= 16'hB2B2;
        end else begin
            i2c_done <= 1'b0;
            case (m_phase)
                0: if ((i2c_read_en || i2c_write_en) && mode != 1) begin
                    m_phase <= 1; m_cnt <= 2;
                    m_wr <= i2c_write_en; m_reg <= i2c_reg_addr; m_wd <= i2c_data_in;
                end
                1: if (m_cnt == 0) begin
                    i2c_busy <= 1'b1; m_cnt <= 5; m_phase <= 2;
                end else m_cnt <= m_cnt - 1;
                2: if (mode != 2) begin
                    if (m_cnt == 0) begin
                        i2c_busy <= 1'b0; i2c_done <= 1'b1; i2c_status <= 4'hA;
                        if (m_wr) mem[m_reg] <= m_wd;
                        else      i2c_data_out <= mem[m_reg];
                        m_phase <= 0;
                    end else m_cnt <= m_cnt - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    int          cyc = 0;
    int          ready_cyc, en_rise_cyc, en_fall_cyc, busy_rise_cyc, busy_fall_cyc, rsp_cyc;
    logic        cap_rd, cap_wr;
    logic [6:0]  cap_chip;
    logic [7:0]  cap_reg;
    logic [15:0] cap_data;
    logic        prev_en = 1'b0, prev_busy = 1'b0;
    logic [NR-1:0] prev_ready = '0;
    logic        overlap = 1'b0, ready_wide = 1'b0, both_en = 1'b0;
    logic [NR-1:0] grant_log [$];

    task automatic step();
        logic en;
        @(posedge clk);
        #1;
        cyc++;
        en = i2c_read_en | i2c_write_en;
        if (|(req_ready & rsp_valid)) overlap = 1'b1;
        if (i2c_read_en && i2c_write_en) both_en = 1'b1;
        if (|req_ready) begin
            if (|prev_ready) ready_wide = 1'b1;
            grant_log.push_back(req_ready);
            ready_cyc = cyc;
            req_valid = req_valid & ~req_ready;
        end
        if (en && !prev_en) begin
            en_rise_cyc = cyc; cap_rd = i2c_read_en; cap_wr = i2c_write_en;
            cap_chip = i2c_chip_addr; cap_reg = i2c_reg_addr; cap_data = i2c_data_in;
        end
        if (!en && prev_en) en_fall_cyc = cyc;
        if (i2c_busy && !prev_busy) busy_rise_cyc = cyc;
        if (!i2c_busy && prev_busy) busy_fall_cyc = cyc;
        if (|rsp_valid) rsp_cyc = cyc;
        prev_en = en; prev_busy = i2c_busy; prev_ready = req_ready;
    endtask

    task automatic wait_rsp(input int budget, output logic got);
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (|rsp_valid) got = 1'b1;
        end
    endtask

    task automatic wait_grant(input int budget, output logic got);
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (|req_ready) got = 1'b1;
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] chip,
                           input logic [7:0] ra, input logic [15:0] wd);
        req_rw[i] = rw;
        req_chip_addr[i*7 +: 7] = chip;
        req_reg_addr[i*8 +: 8] = ra;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        step(); step();
        total++; if ({req_ready, rsp_valid, rsp_timeout} !== '0) begin bad++;
            $display("FAIL reset_handshake: got %b want 0", {req_ready, rsp_valid, rsp_timeout}); end
        total++; if ({i2c_read_en, i2c_write_en} !== 2'b00) begin bad++;
            $display("FAIL reset_enables: got %b want 00", {i2c_read_en, i2c_write_en}); end
        total++; if ({rsp_rdata, rsp_status, i2c_chip_addr, i2c_reg_addr, i2c_data_in} !== '0) begin bad++;
            $display("FAIL reset_data: got %h want 0", {rsp_rdata, rsp_status, i2c_chip_addr, i2c_reg_addr, i2c_data_in}); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic got;
        set_req(0, 1'b0, 7'h0F, 8'h00, 16'h0000);
        req_valid[0] = 1'b1;
        wait_rsp(60, got);
        total++; if (!got) begin bad++; $display("FAIL read_rsp_seen: got none want rsp_valid"); end
        total++; if (grant_log[grant_log.size()-1] !== 4'b0001) begin bad++;
            $display("FAIL read_ready: got %b want 0001", grant_log[grant_log.size()-1]); end
        total++; if (en_rise_cyc !== ready_cyc + 1) begin bad++;
            $display("FAIL read_en_latency: got %0d want %0d", en_rise_cyc - ready_cyc, 1); end
        total++; if ({cap_rd, cap_wr, cap_chip, cap_reg} !== {1'b1, 1'b0, 7'h0F, 8'h00}) begin bad++;
            $display("FAIL read_cmd: got %h want %h", {cap_rd, cap_wr, cap_chip, cap_reg}, {1'b1, 1'b0, 7'h0F, 8'h00}); end
        total++; if (en_fall_cyc !== busy_rise_cyc + 1) begin bad++;
            $display("FAIL read_en_until_busy: got fall %0d want %0d", en_fall_cyc, busy_rise_cyc + 1); end
        total++; if ({rsp_valid, rsp_rdata, rsp_timeout, rsp_status} !== {4'b0001, 16'hA1A1, 1'b0, 4'hA}) begin bad++;
            $display("FAIL read_rsp: got %h want %h", {rsp_valid, rsp_rdata, rsp_timeout, rsp_status}, {4'b0001, 16'hA1A1, 1'b0, 4'hA}); end
        total++; if (rsp_cyc !== busy_fall_cyc + 1) begin bad++;
            $display("FAIL read_rsp_latency: got %0d want 1", rsp_cyc - busy_fall_cyc); end
    endtask

    task automatic test_round_robin();
        logic got;
        do_reset();
        grant_log.delete();
        set_req(0, 1'b0, 7'h0F, 8'h00, 16'h0000);
        set_req(2, 1'b0, 7'h0F, 8'h01, 16'h0000);
        req_valid = 4'b0101;
        wait_rsp(60, got);
        total++; if (!got || rsp_valid !== 4'b0001 || rsp_rdata !== 16'hA1A1) begin bad++;
            $display("FAIL rr_first: got %b/%h want 0001/a1a1", rsp_valid, rsp_rdata); end
        req_valid[0] = 1'b1;
        wait_rsp(60, got);
        total++; if (!got || rsp_valid !== 4'b0100 || rsp_rdata !== 16'hB2B2) begin bad++;
            $display("FAIL rr_second: got %b/%h want 0100/b2b2", rsp_valid, rsp_rdata); end
        wait_rsp(60, got);
        total++; if (!got || rsp_valid !== 4'b0001) begin bad++;
            $display("FAIL rr_third: got %b want 0001", rsp_valid); end
        total++; if (grant_log.size() !== 3 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b0100 || grant_log[2] !== 4'b0001) begin bad++;
            $display("FAIL rr_order: got %0d grants want 0001,0100,0001", grant_log.size()); end
    endtask

    task automatic test_write();
        logic got;
        set_req(1, 1'b1, 7'h0F, 8'h05, 16'h1234);
        req_valid[1] = 1'b1;
        wait_rsp(60, got);
        total++; if (!got) begin bad++; $display("FAIL wr_rsp_seen: got none want rsp_valid"); end
        total++; if ({cap_wr, cap_rd, cap_reg, cap_data} !== {1'b1, 1'b0, 8'h05, 16'h1234}) begin bad++;
            $display("FAIL wr_cmd: got %h want %h", {cap_wr, cap_rd, cap_reg, cap_data}, {1'b1, 1'b0, 8'h05, 16'h1234}); end
        total++; if ({rsp_valid, rsp_rdata, rsp_timeout} !== {4'b0010, 16'h0000, 1'b0}) begin bad++;
            $display("FAIL wr_rsp: got %h want %h", {rsp_valid, rsp_rdata, rsp_timeout}, {4'b0010, 16'h0000, 1'b0}); end
        set_req(1, 1'b0, 7'h0F, 8'h05, 16'h0000);
        req_valid[1] = 1'b1;
        wait_rsp(60, got);
        total++; if (!got || rsp_valid !== 4'b0010 || rsp_rdata !== 16'h1234) begin bad++;
            $display("FAIL wr_readback: got %b/%h want 0010/1234", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_start_timeout();
        logic got;
        mode = 1;
        set_req(2, 1'b0, 7'h0F, 8'h00, 16'h0000);
        set_req(3, 1'b0, 7'h0F, 8'h00, 16'h0000);
        req_valid = 4'b1100;
        wait_rsp(TO + 20, got);
        mode = 0;
        total++; if (!got || rsp_valid !== 4'b0100 || rsp_timeout !== 1'b1 || rsp_rdata !== 16'h0) begin bad++;
            $display("FAIL sto_rsp: got %b/%b/%h want 0100/1/0000", rsp_valid, rsp_timeout, rsp_rdata); end
        total++; if (rsp_cyc - en_rise_cyc !== TO) begin bad++;
            $display("FAIL sto_latency: got %0d want %0d", rsp_cyc - en_rise_cyc, TO); end
        total++; if ({i2c_read_en, i2c_write_en} !== 2'b00) begin bad++;
            $display("FAIL sto_en_low: got %b want 00", {i2c_read_en, i2c_write_en}); end
        wait_rsp(60, got);
        total++; if (grant_log[grant_log.size()-1] !== 4'b1000) begin bad++;
            $display("FAIL sto_next_grant: got %b want 1000", grant_log[grant_log.size()-1]); end
        total++; if (!got || rsp_valid !== 4'b1000 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'hA1A1) begin bad++;
            $display("FAIL sto_next_rsp: got %b/%b/%h want 1000/0/a1a1", rsp_valid, rsp_timeout, rsp_rdata); end
    endtask

    task automatic test_done_timeout();
        logic got;
        mode = 2;
        set_req(1, 1'b0, 7'h0F, 8'h01, 16'h0000);
        req_valid[1] = 1'b1;
        wait_rsp(TO + 20, got);
        total++; if (!got || rsp_valid !== 4'b0010 || rsp_timeout !== 1'b1 || rsp_rdata !== 16'h0) begin bad++;
            $display("FAIL dto_rsp: got %b/%b/%h want 0010/1/0000", rsp_valid, rsp_timeout, rsp_rdata); end
        total++; if (rsp_cyc - en_rise_cyc !== TO) begin bad++;
            $display("FAIL dto_latency: got %0d want %0d", rsp_cyc - en_rise_cyc, TO); end
        total++; if (en_fall_cyc !== busy_rise_cyc + 1) begin bad++;
            $display("FAIL dto_en_drop: got fall %0d want %0d", en_fall_cyc, busy_rise_cyc + 1); end
    endtask

    task automatic test_reset_mid_op();
        logic got;
        int   n_rsp;
        n_rsp = 0;
        set_req(3, 1'b0, 7'h2A, 8'h00, 16'h0000);
        req_valid[3] = 1'b1;
        wait_grant(10, got);
        total++; if (!got || req_ready !== 4'b1000) begin bad++;
            $display("FAIL rst_pre_grant: got %b want 1000", req_ready); end
        for (int k = 0; k < 6; k++) begin
            step();
            if (|rsp_valid) n_rsp++;
        end
        reset = 1'b1;
        #1;
        total++; if ({i2c_read_en, i2c_write_en, i2c_chip_addr} !== '0) begin bad++;
            $display("FAIL rst_async_done: got %h want 0", {i2c_read_en, i2c_write_en, i2c_chip_addr}); end
        step(); step();
        mode = 0;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (|rsp_valid) n_rsp++;
        end
        total++; if (n_rsp !== 0) begin bad++;
            $display("FAIL rst_no_rsp: got %0d responses want 0", n_rsp); end
        set_req(1, 1'b0, 7'h0F, 8'h00, 16'h0000);
        set_req(3, 1'b0, 7'h0F, 8'h01, 16'h0000);
        req_valid = 4'b1010;
        wait_grant(10, got);
        total++; if (!got || req_ready !== 4'b0010) begin bad++;
            $display("FAIL rst_rr_ptr: got %b want 0010", req_ready); end
        step();
        total++; if (i2c_read_en !== 1'b1) begin bad++;
            $display("FAIL rst_en_high: got %b want 1", i2c_read_en); end
        reset = 1'b1;
        #1;
        total++; if ({i2c_read_en, i2c_write_en} !== 2'b00) begin bad++;
            $display("FAIL rst_async_busy: got %b want 00", {i2c_read_en, i2c_write_en}); end
        step(); step();
        reset = 1'b0;
        wait_rsp(60, got);
        total++; if (!got || rsp_valid !== 4'b1000 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'hB2B2) begin bad++;
            $display("FAIL rst_after: got %b/%b/%h want 1000/0/b2b2", rsp_valid, rsp_timeout, rsp_rdata); end
    endtask

    task automatic test_invariants();
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL inv_overlap: got 1 want 0"); end
        total++; if (ready_wide !== 1'b0) begin bad++; $display("FAIL inv_ready_pulse: got wide want 1-cycle"); end
        total++; if (both_en !== 1'b0) begin bad++; $display("FAIL inv_both_en: got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_start_timeout();
        test_done_timeout();
        test_reset_mid_op();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
